// File: rtl/cordic_vec_iter_pkg.sv
// Shared constants, state encoding and arctangent table for the folded vectoring CORDIC.
// Angles are signed fixed point with ANG_FRAC fractional bits per radian.
package cordic_pkg;

    localparam int ANG_FRAC = 20;
    localparam int HALF_PI  = 1647099;
    localparam int PI       = 3294199;
    localparam int ATAN_N   = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // atan(2^-i) scaled by 2^ANG_FRAC; entries beyond the table return 0.
    function automatic int atan_lut(input int unsigned idx);
        case (idx)
            0:       atan_lut = 823549;
            1:       atan_lut = 486170;
            2:       atan_lut = 256879;
            3:       atan_lut = 130396;
            4:       atan_lut = 65451;
            5:       atan_lut = 32757;
            6:       atan_lut = 16383;
            7:       atan_lut = 8192;
            8:       atan_lut = 4096;
            9:       atan_lut = 2048;
            10:      atan_lut = 1024;
            11:      atan_lut = 512;
            12:      atan_lut = 256;
            13:      atan_lut = 128;
            14:      atan_lut = 64;
            15:      atan_lut = 32;
            16:      atan_lut = 16;
            17:      atan_lut = 8;
            18:      atan_lut = 4;
            19:      atan_lut = 2;
            default: atan_lut = 0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_vec_iter_if.sv
// Valid/ready sample-in and result-out bus of the vectoring CORDIC.
// The slave modport is the CORDIC's view; master is the producer/consumer side.
interface cordic_vec_iter_if #(
    parameter int DW = 16,
    parameter int AW = 24
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] x_i;
    logic signed [DW-1:0] y_i;
    logic                 out_valid;
    logic                 out_ready;
    logic        [DW:0]   mag_o;
    logic signed [AW-1:0] ang_o;

    modport slave (
        input  in_valid, x_i, y_i, out_ready,
        output in_ready, out_valid, mag_o, ang_o
    );

    modport master (
        output in_valid, x_i, y_i, out_ready,
        input  in_ready, out_valid, mag_o, ang_o
    );
endinterface

// File: rtl/cordic_vec_iter_step.sv
// One vectoring micro-rotation: drives y toward zero and accumulates the rotated angle.
// Purely combinational; the shift distance is the iteration index.
module cordic_vec_step #(
    parameter int XW = 18,
    parameter int AW = 24,
    parameter int SW = 5
) (
    input  logic signed [XW-1:0] i_x,
    input  logic signed [XW-1:0] i_y,
    input  logic signed [AW-1:0] i_z,
    input  logic        [SW-1:0] i_shift,
    input  logic signed [AW-1:0] i_atan,
    output logic signed [XW-1:0] o_x,
    output logic signed [XW-1:0] o_y,
    output logic signed [AW-1:0] o_z
);
    logic signed [XW-1:0] w_xs;
    logic signed [XW-1:0] w_ys;

    always_comb begin
        w_xs = i_x >>> i_shift;
        w_ys = i_y >>> i_shift;
        if (!i_y[XW-1]) begin
            o_x = i_x + w_ys;
            o_y = i_y - w_xs;
            o_z = i_z + i_atan;
        end else begin
            o_x = i_x - w_ys;
            o_y = i_y + w_xs;
            o_z = i_z - i_atan;
        end
    end

endmodule

// File: rtl/cordic_vec_iter.sv
// Folded vectoring CORDIC: (x,y) -> (K*|v|, atan2(y,x)), one micro-rotation per clock.
// Quadrant pre-rotation on capture keeps the iterated vector in the right half-plane.
module cordic_vec_iter
    import cordic_pkg::*;
#(
    parameter int DW   = 16,
    parameter int AW   = 24,
    parameter int ITER = 16
) (
    input logic              clk,
    input logic              rst_n,
    cordic_vec_iter_if.slave bus
);
    localparam int XW = DW + 2;
    localparam int SW = 5;
    localparam logic [SW-1:0]        LAST   = SW'(ITER - 1);
    localparam logic signed [AW-1:0] Z_PHP  = AW'(HALF_PI);
    localparam logic signed [AW-1:0] Z_NHP  = AW'(-HALF_PI);

    state_t r_state;
    state_t w_next;

    logic signed [XW-1:0] r_x;
    logic signed [XW-1:0] r_y;
    logic signed [AW-1:0] r_z;
    logic        [SW-1:0] r_iter;
    logic                 r_zero;

    logic signed [XW-1:0] w_xe;
    logic signed [XW-1:0] w_ye;
    logic signed [XW-1:0] w_cap_x;
    logic signed [XW-1:0] w_cap_y;
    logic signed [AW-1:0] w_cap_z;
    logic                 w_cap_zero;
    logic signed [AW-1:0] w_atan;
    logic signed [XW-1:0] w_step_x;
    logic signed [XW-1:0] w_step_y;
    logic signed [AW-1:0] w_step_z;
    logic                 w_accept;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid) w_next = RUN;
            RUN:     if (r_iter == LAST) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from state; the result registers hold while DONE waits.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.mag_o     = '0;
        bus.ang_o     = '0;
        unique case (r_state)
            IDLE: bus.in_ready = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.mag_o     = r_x[DW:0];
                bus.ang_o     = r_zero ? '0 : r_z;
            end
            default: ;
        endcase
    end

    assign w_accept = (r_state == IDLE) && bus.in_valid;

    // Left half-plane inputs are turned by -/+90 degrees so iteration starts with x >= 0.
    always_comb begin
        w_xe       = {{(XW-DW){bus.x_i[DW-1]}}, bus.x_i};
        w_ye       = {{(XW-DW){bus.y_i[DW-1]}}, bus.y_i};
        w_cap_x    = w_xe;
        w_cap_y    = w_ye;
        w_cap_z    = '0;
        w_cap_zero = (bus.x_i == '0) && (bus.y_i == '0);
        if (w_xe[XW-1]) begin
            if (!w_ye[XW-1]) begin
                w_cap_x = w_ye;
                w_cap_y = -w_xe;
                w_cap_z = Z_PHP;
            end else begin
                w_cap_x = -w_ye;
                w_cap_y = w_xe;
                w_cap_z = Z_NHP;
            end
        end
    end

    assign w_atan = AW'(atan_lut(32'(r_iter)));

    cordic_vec_step #(
        .XW (XW),
        .AW (AW),
        .SW (SW)
    ) u_step (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_z     (r_z),
        .i_shift (r_iter),
        .i_atan  (w_atan),
        .o_x     (w_step_x),
        .o_y     (w_step_y),
        .o_z     (w_step_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_iter <= '0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_x    <= w_cap_x;
            r_y    <= w_cap_y;
            r_z    <= w_cap_z;
            r_iter <= '0;
            r_zero <= w_cap_zero;
        end else if (r_state == RUN) begin
            r_x    <= w_step_x;
            r_y    <= w_step_y;
            r_z    <= w_step_z;
            r_iter <= r_iter + SW'(1);
        end
    end

endmodule

// File: tb/tb_cordic_vec_iter.sv
// Bench for cordic_vec_iter: integer reference of the vectoring algorithm plus real-valued
// polar accuracy checks, directed vectors, backpressure and mid-run reset.
module tb_cordic_vec_iter;

    localparam int DW   = 16;
    localparam int AW   = 24;
    localparam int ITER = 16;

    typedef struct {
        longint mag;
        longint ang;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   acc_cyc;
    real  kgain;
    res_t exp_q[$];

    int atan_tab [0:19] = '{823549, 486170, 256879, 130396, 65451, 32757, 16383, 8192,
                            4096, 2048, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_vec_iter_if #(.DW(DW), .AW(AW)) bus ();

    cordic_vec_iter #(.DW(DW), .AW(AW), .ITER(ITER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic void chk(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endfunction

    function automatic void chk_tol(input string name, input longint act, input longint req,
                                    input longint tol);
        longint d;
        n_vec++;
        d = act - req;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d +/- %0d", name, act, req, tol);
        end
    endfunction

    // Reference: quadrant fold then ITER sign-of-y decisions on plain integers.
    function automatic res_t model(input int x, input int y);
        int xx, yy, zz, t;
        res_t r;
        if (x >= 0) begin
            xx = x;  yy = y;  zz = 0;
        end else if (y >= 0) begin
            xx = y;  yy = -x; zz = 1647099;
        end else begin
            xx = -y; yy = x;  zz = -1647099;
        end
        for (int i = 0; i < ITER; i++) begin
            t = xx;
            if (yy >= 0) begin
                xx = xx + (yy >>> i);
                yy = yy - (t >>> i);
                zz = zz + atan_tab[i];
            end else begin
                xx = xx - (yy >>> i);
                yy = yy + (t >>> i);
                zz = zz - atan_tab[i];
            end
        end
        r.mag = longint'(xx);
        r.ang = (x == 0 && y == 0) ? 0 : longint'(zz);
        return r;
    endfunction

    // Scoreboard push on every accepted sample.
    always @(posedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready)
            exp_q.push_back(model(int'(bus.x_i), int'(bus.y_i)));
    end

    // Compare every cycle a result is presented.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected out_valid", 1, 0);
            end else begin
                chk("mag_o vs model", longint'(bus.mag_o), exp_q[0].mag);
                chk("ang_o vs model", longint'(bus.ang_o), exp_q[0].ang);
                chk("in_ready while out_valid", longint'(bus.in_ready), 0);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    function automatic void accuracy(input string tag, input int x, input int y);
        real    rm, ra;
        longint mag, ang, tol;
        mag = longint'(bus.mag_o);
        ang = longint'(bus.ang_o);
        rm  = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * kgain;
        chk_tol({tag, " mag accuracy"}, mag, $rtoi(rm + 0.5), 2 + ITER);
        if (x == 0 && y == 0) begin
            chk({tag, " zero ang"}, ang, 0);
            chk({tag, " zero mag<=2"}, longint'(mag <= 2), 1);
        end else begin
            ra  = $atan2(real'(y), real'(x)) * 1048576.0;
            tol = 48 + ((2 * ITER + 4) * 1048576) / (mag > 0 ? mag : 1);
            chk_tol({tag, " ang accuracy"}, ang, $rtoi(ra + (ra < 0 ? -0.5 : 0.5)), tol);
        end
    endfunction

    task automatic send(input int x, input int y);
        int k;
        k = 0;
        while (!bus.in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.in_ready) chk("in_ready wait timeout", 0, 1);
        bus.in_valid = 1'b1;
        bus.x_i      = DW'(x);
        bus.y_i      = DW'(y);
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) chk("out_valid wait timeout", 0, 1);
    endtask

    task automatic run_check(input string tag, input int x, input int y);
        int lat;
        bus.out_ready = 1'b1;
        send(x, y);
        wait_out(lat);
        chk({tag, " latency"}, lat, ITER + 1);
        accuracy(tag, x, y);
        @(posedge clk); #1;
        chk({tag, " out_valid drops"}, longint'(bus.out_valid), 0);
        chk({tag, " in_ready back"}, longint'(bus.in_ready), 1);
    endtask

    initial begin
        res_t r;
        int   lat, t0;
        longint m0, a0;

        bus.in_valid  = 1'b0;
        bus.x_i       = '0;
        bus.y_i       = '0;
        bus.out_ready = 1'b1;

        kgain = 1.0;
        for (int i = 0; i < ITER; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2 * i));

        // Hand-worked results pin the reference itself.
        r = model(1000, 0);
        chk("pin model 1000,0 mag", r.mag, 1649);
        chk("pin model 1000,0 ang", r.ang, 1197);
        r = model(1000, 1000);
        chk("pin model 1000,1000 mag", r.mag, 2335);
        chk("pin model 1000,1000 ang", r.ang, 823245);
        r = model(0, 0);
        chk("pin model 0,0 mag", r.mag, 0);
        chk("pin model 0,0 ang", r.ang, 0);

        #2;
        chk("reset out_valid", longint'(bus.out_valid), 0);
        chk("reset in_ready", longint'(bus.in_ready), 1);
        chk("reset mag_o", longint'(bus.mag_o), 0);
        chk("reset ang_o", longint'(bus.ang_o), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_check("1000,0", 1000, 0);
        run_check("1000,1000", 1000, 1000);
        run_check("0,-1000", 0, -1000);
        run_check("-1000,0", -1000, 0);
        chk("-1000,0 ang positive", longint'(dut.r_z > 0), 1);
        run_check("-32768,-32768", -32768, -32768);
        run_check("0,0", 0, 0);
        run_check("-1000,500", -1000, 500);
        run_check("300,-7000", 300, -7000);
        run_check("32767,-32768", 32767, -32768);

        // Back-to-back throughput with the consumer always ready.
        bus.out_ready = 1'b1;
        send(1234, -567);
        t0 = acc_cyc;
        wait_out(lat);
        send(-2222, -3333);
        chk("throughput period", acc_cyc - t0, ITER + 2);
        wait_out(lat);
        @(posedge clk); #1;

        // in_valid during RUN must not be consumed.
        send(400, -900);
        bus.in_valid = 1'b1;
        bus.x_i      = -16'sd5;
        bus.y_i      = 16'sd77;
        repeat (5) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_out(lat);
        accuracy("400,-900 busy", 400, -900);
        @(posedge clk); #1;

        // Backpressure: hold DONE for 10 cycles with a competing sample offered.
        bus.out_ready = 1'b0;
        send(-5000, 12000);
        wait_out(lat);
        m0 = longint'(bus.mag_o);
        a0 = longint'(bus.ang_o);
        bus.in_valid = 1'b1;
        bus.x_i      = 16'sd123;
        bus.y_i      = 16'sd456;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall out_valid", longint'(bus.out_valid), 1);
            chk("stall in_ready", longint'(bus.in_ready), 0);
            chk("stall mag stable", longint'(bus.mag_o), m0);
            chk("stall ang stable", longint'(bus.ang_o), a0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release out_valid drops", longint'(bus.out_valid), 0);
        run_check("after stall", 777, 888);

        // Asynchronous reset at iteration 5 discards the in-flight sample.
        send(2000, -1500);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid-run reset out_valid", longint'(bus.out_valid), 0);
        chk("mid-run reset in_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset out_valid", longint'(bus.out_valid), 0);
        chk("post-reset in_ready", longint'(bus.in_ready), 1);
        run_check("post-reset 2000,-1500", 2000, -1500);

        repeat (3) @(posedge clk);
        #1 chk("scoreboard drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

endmodule
